uart_tx_word: RTL and testbench
===============================

# uart_tx_word

Serial transmitter for the debug/boot UART link: accepts one 32-bit word per handshake and sends it as four 8N1 bytes, least-significant byte first, each byte LSB-first, at 9600 baud. It is the outbound counterpart of the word-assembling UART receiver. The receiver packs four received bytes into one instruction word; this block unpacks a word into four bytes in the same order, so a word echoed back through both blocks is bit-identical.

## Interface
Parameters:
- COUNT_MAX, 5207: clocks per bit minus 1 (5208 clocks/bit = 9600 baud at 50 MHz); legal range 1..8191.

Ports:
- Reset rst_p, asynchronous, active-high; clock clk_capture.
- clk_capture  in  1  system clock; all state updates on its rising edge.
- rst_p  in  1  asynchronous active-high reset.
- tx_valid  in  1  word available on tx_data.
- tx_data  in  32  word to send; sampled only on the accept edge.
- tx_ready  out  1  block can accept a word; combinational, = (state == IDLE).
- uart_tx  out  1  serial line, registered, idle high.
- tx_busy  out  1  registered, high from the cycle after accept until the frame completes.
- tx_done  out  1  registered, one-cycle pulse after the stop bit of byte 3.
- word_count  out  16  registered, number of completed words; wraps 0xFFFF -> 0x0000.

## Operation
- Accept: a rising edge with tx_valid && tx_ready latches tx_data into shift_word[31:0] and moves the state to START. Byte index, bit index and baud counter are cleared on accept.
- tx_valid while tx_ready is low is ignored. It is neither queued nor latched.
- States:
  - IDLE: uart_tx = 1.
  - START: uart_tx = 0 for COUNT_MAX+1 clocks, then DATA.
  - DATA: uart_tx = current byte bit[bit_idx], bit_idx 0..7, each bit held for COUNT_MAX+1 clocks, then STOP.
  - STOP: uart_tx = 1 for COUNT_MAX+1 clocks.
- STOP exit:
  - byte_idx < 3: byte_idx increments and the state goes to START, with no idle gap between bytes.
  - byte_idx == 3: the state goes to IDLE.
- Byte order: byte_idx 0 sends tx_data[7:0], 1 sends [15:8], 2 sends [23:16], 3 sends [31:24].
- Baud counter: 13 bits, counts 0..COUNT_MAX. The bit ends and the counter wraps to 0 when it equals COUNT_MAX.
- Byte index is 2 bits and bit index is 3 bits; neither wraps except on the transitions defined above.
- tx_done and word_count are updated on the same edge as the STOP -> IDLE transition.
- Reset (any time, including mid-frame): all registers are cleared immediately and asynchronously. The partial frame is abandoned and is not resumed.

Reset values:
- uart_tx = 1, tx_busy = 0, tx_done = 0, word_count = 0.
- state = IDLE, so tx_ready = 1.

## Timing
- Let B = COUNT_MAX+1.
- Edge 0: accept edge. uart_tx goes low and tx_busy goes high at edge 0 (registered), so the start bit is visible in cycle 1.
- One byte occupies 10·B clocks. One word occupies 40·B clocks from the start bit of byte 0 to the end of the stop bit of byte 3.
- tx_done is high for exactly one cycle, in the cycle following the last stop-bit clock (edge 40·B). In that same cycle tx_busy = 0 and tx_ready = 1.
- Back-to-back words: with tx_valid held high, the next word is accepted in the tx_done cycle. The line therefore stays idle-high for exactly one clock between words. Word n+1 has its start bit at edge 40·B + 1 relative to word n's accept.
- tx_data may change freely after the accept edge.
- Releasing rst_p synchronously to clk_capture is the integrator's responsibility.

## Test plan
All cases use COUNT_MAX = 3, so B = 4 clocks/bit and 160 clocks/word.
- Reset: assert rst_p mid-cycle with no clock edge -> uart_tx = 1, tx_ready = 1, tx_busy = 0, tx_done = 0, word_count = 0 immediately.
- Single word: tx_data = 0xA53C0F81, one-cycle tx_valid -> bit-accurate line stream for bytes 0x81, 0x0F, 0x3C, 0xA5. Each byte is a 0 start bit, 8 data bits LSB-first and a 1 stop bit, 4 clocks per bit. tx_done pulses once at edge 160 and word_count = 1.
- Back-to-back: tx_valid held high with words 0x00000000 then 0xFFFFFFFF -> second accept in the tx_done cycle. There is exactly one idle-high clock between frames, and word_count = 2.
- Busy ignore: pulse tx_valid with 0x12345678 at clock 50 of a frame carrying 0xDEADBEEF -> only 0xDEADBEEF is transmitted and tx_ready stays 0 until completion.
- Reset mid-frame: assert rst_p at clock 70 of a frame -> uart_tx goes high immediately, word_count = 0 and tx_done never pulses. A new word sent after release is transmitted correctly from its start bit.
- Loopback: connect uart_tx to a receiver model and send three words -> three identical words are received and word_count = 3.

Source files
------------

// File: rtl/uart_tx_word.sv
// uart_tx_word: sends one 32-bit word as four 8N1 bytes on the UART line.
// Bytes go out least-significant first and each byte is sent LSB-first.
// This matches the byte order of the word-assembling receiver, so a word
// echoed through both blocks comes back bit-identical.
//
// Handshake: a word is accepted on a rising clk_capture edge where
// tx_valid && tx_ready. tx_ready is high only in IDLE. tx_data is sampled on
// that edge only. tx_valid while tx_ready is low is ignored and not queued.
module uart_tx_word #(
    parameter int COUNT_MAX = 5207
) (
    input  logic        clk_capture,
    input  logic        rst_p,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [15:0] word_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [12:0] BAUD_LAST = 13'(COUNT_MAX);

    state_t      state;
    logic [31:0] shift_word;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [12:0] baud_cnt;

    logic [7:0]  cur_byte;
    logic [2:0]  next_bit_idx;
    logic        bit_end;

    assign tx_ready  = (state == IDLE);
    assign dbg_state = state;

    // Select the byte being sent and detect the last clock of the current bit.
    always_comb begin
        cur_byte     = 8'h00;
        next_bit_idx = bit_idx + 3'd1;
        bit_end      = (baud_cnt == BAUD_LAST);
        case (byte_idx)
            2'd0:    cur_byte = shift_word[7:0];
            2'd1:    cur_byte = shift_word[15:8];
            2'd2:    cur_byte = shift_word[23:16];
            default: cur_byte = shift_word[31:24];
        endcase
    end

    // Framing FSM. The line level is registered and is set one edge ahead of
    // the bit it represents, so each level holds for exactly COUNT_MAX+1 clocks.
    always_ff @(posedge clk_capture or posedge rst_p) begin
        if (rst_p) begin
            state      <= IDLE;
            shift_word <= 32'h0000_0000;
            byte_idx   <= 2'd0;
            bit_idx    <= 3'd0;
            baud_cnt   <= 13'd0;
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            word_count <= 16'h0000;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (tx_valid && tx_ready) begin
                        shift_word <= tx_data;
                        byte_idx   <= 2'd0;
                        bit_idx    <= 3'd0;
                        baud_cnt   <= 13'd0;
                        uart_tx    <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= 13'd0;
                        uart_tx  <= cur_byte[bit_idx];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= 13'd0;
                        if (bit_idx == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_idx <= next_bit_idx;
                            uart_tx <= cur_byte[next_bit_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= 13'd0;
                        if (byte_idx != 2'd3) begin
                            // Next byte starts straight away, no idle gap.
                            byte_idx <= byte_idx + 2'd1;
                            bit_idx  <= 3'd0;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end else begin
                            uart_tx    <= 1'b1;
                            tx_busy    <= 1'b0;
                            tx_done    <= 1'b1;
                            word_count <= word_count + 16'h0001;
                            state      <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 13'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word with COUNT_MAX = 3 (4 clocks per bit, 160 per word).
// Stimulus pushes each accepted word onto exp_q. A line receiver model pops
// and compares every word it decodes from uart_tx.
`timescale 1ns/1ps
module tb_uart_tx_word;

    localparam int CM    = 3;
    localparam int B     = CM + 1;
    localparam int FRAME = 40 * B;
    localparam int CLK_P = 10;

    logic        clk_capture = 1'b0;
    logic        rst_p       = 1'b0;
    logic        tx_valid    = 1'b0;
    logic [31:0] tx_data     = 32'h0;
    logic        tx_ready;
    logic        uart_tx;
    logic        tx_busy;
    logic        tx_done;
    logic [15:0] word_count;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic        cap_line [0:FRAME-1];

    uart_tx_word #(.COUNT_MAX(CM)) dut (
        .clk_capture(clk_capture),
        .rst_p      (rst_p),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .uart_tx    (uart_tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .word_count (word_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #(CLK_P/2) clk_capture = ~clk_capture;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time expired, required test completion");
        $fatal(1, "watchdog");
    end

    // ---------------- comparison helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Expected line level in cycle c (1-based) after accepting word w.
    function automatic logic exp_line(input logic [31:0] w, input int c);
        int         byte_i = (c - 1) / (10 * B);
        int         slot   = ((c - 1) / B) % 10;
        logic [7:0] by     = w[8*byte_i +: 8];
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return by[slot-1];
    endfunction

    // ---------------- receiver model / monitor ----------------
    bit          rx_active = 1'b0;
    int          rx_cnt    = 0;
    int          rx_idx    = 0;
    int          rx_nbytes = 0;
    logic [7:0]  rx_byte   = 8'h0;
    logic [31:0] rx_word   = 32'h0;
    logic [31:0] rx_exp;

    // Samples the line in the second clock of every bit and assembles words.
    always @(negedge clk_capture) begin
        if (rst_p) begin
            rx_active = 1'b0;
            rx_nbytes = 0;
        end else if (!rx_active) begin
            if (uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % B == 1) begin
                rx_idx = rx_cnt / B;
                if (rx_idx == 0) begin
                    check_bit("rx_start_bit", uart_tx, 1'b0);
                end else if (rx_idx <= 8) begin
                    rx_byte[rx_idx-1] = uart_tx;
                end else begin
                    check_bit("rx_stop_bit", uart_tx, 1'b1);
                    rx_word[8*rx_nbytes +: 8] = rx_byte;
                    rx_nbytes++;
                    rx_active = 1'b0;
                    if (rx_nbytes == 4) begin
                        rx_nbytes = 0;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL rx_unexpected_word: got 0x%08h required no word", rx_word);
                        end else begin
                            rx_exp = exp_q.pop_front();
                            check("rx_word", rx_word, rx_exp);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk_capture);
        #2;
        rst_p = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk_capture);
        #1;
        rst_p = 1'b0;
    endtask

    // Waits until tx_ready, lets the next edge accept, records that word.
    task automatic wait_accept(output time t, output logic done_at, output logic line_at);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(posedge clk_capture);
            #1;
            n++;
        end
        total++;
        if (tx_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
        end
        done_at = tx_done;
        line_at = uart_tx;
        @(posedge clk_capture);
        exp_q.push_back(tx_data);
        t = $time;
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        time  t;
        logic d, l;
        @(posedge clk_capture);
        #1;
        tx_valid = 1'b1;
        tx_data  = w;
        wait_accept(t, d, l);
        tx_valid = 1'b0;
        tx_data  = $urandom;
    endtask

    // Follows one frame from its accept edge to tx_done, capturing the line.
    // pulse_at != 0 drives a stray tx_valid during that cycle of the frame.
    task automatic finish_frame(input string name, input int pulse_at);
        int   done_cyc  = 0;
        logic ready_lk  = 1'b0;
        logic busy_gap  = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk_capture);
            if (c <= FRAME) begin
                cap_line[c-1] = uart_tx;
                if (tx_ready !== 1'b0) ready_lk = 1'b1;
                if (tx_busy !== 1'b1)  busy_gap = 1'b1;
            end
            if (pulse_at != 0 && c == pulse_at) begin
                tx_valid = 1'b1;
                tx_data  = 32'h1234_5678;
            end
            if (pulse_at != 0 && c == pulse_at + 1) begin
                tx_valid = 1'b0;
                tx_data  = $urandom;
            end
            if (tx_done === 1'b1) begin
                done_cyc = c;
                break;
            end
        end
        check({name, "_done_cycle"}, 32'(done_cyc), 32'(FRAME + 1));
        check_bit({name, "_busy_at_done"}, tx_busy, 1'b0);
        check_bit({name, "_ready_at_done"}, tx_ready, 1'b1);
        check_bit({name, "_ready_leak"}, ready_lk, 1'b0);
        check_bit({name, "_busy_gap"}, busy_gap, 1'b0);
        @(negedge clk_capture);
        check_bit({name, "_done_one_cycle"}, tx_done, 1'b0);
    endtask

    task automatic check_line(input string name, input logic [31:0] w);
        int mism = -1;
        for (int c = 1; c <= FRAME; c++) begin
            if (mism < 0 && cap_line[c-1] !== exp_line(w, c)) mism = c;
        end
        check({name, "_first_bad_cycle"}, 32'(mism), 32'hFFFF_FFFF);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        time  t1, t2;
        logic d_at, l_at;
        logic seen_done;
        logic seen_busy;

        // Reset asserted between edges: outputs must react with no clock.
        #2;
        rst_p = 1'b1;
        #1;
        check_bit("rst_uart_tx", uart_tx, 1'b1);
        check_bit("rst_tx_ready", tx_ready, 1'b1);
        check_bit("rst_tx_busy", tx_busy, 1'b0);
        check_bit("rst_tx_done", tx_done, 1'b0);
        check("rst_word_count", 32'(word_count), 32'd0);
        @(negedge clk_capture);
        #1;
        rst_p = 1'b0;

        // Single word, bit-accurate line stream.
        send_word(32'hA53C_0F81);
        finish_frame("single", 0);
        check_line("single_line", 32'hA53C_0F81);
        check("single_word_count", 32'(word_count), 32'd1);

        // Back-to-back with tx_valid held high.
        do_reset();
        @(posedge clk_capture);
        #1;
        tx_valid = 1'b1;
        tx_data  = 32'h0000_0000;
        wait_accept(t1, d_at, l_at);
        tx_data  = 32'hFFFF_FFFF;
        wait_accept(t2, d_at, l_at);
        tx_valid = 1'b0;
        tx_data  = $urandom;
        check("b2b_accept_spacing", 32'((t2 - t1) / CLK_P), 32'(FRAME + 1));
        check_bit("b2b_accept_in_done_cycle", d_at, 1'b1);
        check_bit("b2b_idle_clock_high", l_at, 1'b1);
        finish_frame("b2b", 0);
        check_line("b2b_line", 32'hFFFF_FFFF);
        check("b2b_word_count", 32'(word_count), 32'd2);

        // Stray tx_valid while busy must be ignored.
        do_reset();
        send_word(32'hDEAD_BEEF);
        finish_frame("busy", 50);
        check_line("busy_line", 32'hDEAD_BEEF);
        seen_busy = 1'b0;
        repeat (200) begin
            @(negedge clk_capture);
            if (tx_busy !== 1'b0 || uart_tx !== 1'b1) seen_busy = 1'b1;
        end
        check_bit("busy_no_second_word", seen_busy, 1'b0);
        check("busy_word_count", 32'(word_count), 32'd1);

        // Reset in the middle of a frame (word_count is 1 going in).
        send_word(32'h1357_9BDF);
        repeat (70) @(negedge clk_capture);
        #2;
        rst_p = 1'b1;
        exp_q.delete();
        #1;
        check_bit("midrst_uart_tx", uart_tx, 1'b1);
        check_bit("midrst_tx_ready", tx_ready, 1'b1);
        check_bit("midrst_tx_busy", tx_busy, 1'b0);
        check("midrst_word_count", 32'(word_count), 32'd0);
        repeat (2) @(negedge clk_capture);
        #1;
        rst_p = 1'b0;
        seen_done = 1'b0;
        repeat (200) begin
            @(negedge clk_capture);
            if (tx_done !== 1'b0) seen_done = 1'b1;
        end
        check_bit("midrst_no_done", seen_done, 1'b0);
        send_word(32'h2468_ACE1);
        finish_frame("after_rst", 0);
        check_line("after_rst_line", 32'h2468_ACE1);
        check("after_rst_word_count", 32'(word_count), 32'd1);

        // Loopback of three words through the receiver model.
        do_reset();
        send_word(32'hCAFE_F00D);
        finish_frame("loop0", 0);
        send_word(32'h0BAD_C0DE);
        finish_frame("loop1", 0);
        send_word(32'h8000_0001);
        finish_frame("loop2", 0);
        check("loop_word_count", 32'(word_count), 32'd3);

        repeat (20) @(negedge clk_capture);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
